// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out UART receiver: 16x oversampled start detection, mid-bit sampling,
// 9-bit LSB-first word with valid, framing-error and sticky overrun flags for the host.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 9
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 divClk,
  input  logic                 Rx,
  input  logic                 RD,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 Valid,
  output logic                 FrameErr,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   div_q, div_d;
  logic                   tick_q, tick_d;
  logic                   rx_m_q, rx_m_d;
  logic                   rx_s_q, rx_s_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BW-1:0]          bidx_q, bidx_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;

  // Front end: divClk rising-edge pulse and two-flop Rx synchronizer.
  always_comb begin
    div_d  = divClk;
    tick_d = divClk & ~div_q;
    rx_m_d = Rx;
    rx_s_d = rx_m_q;
  end

  // Receive FSM next-state; counters only move on tick, RD acts every cycle.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    valid_d = valid_q & ~RD;
    if (tick_q) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            tcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            bidx_d  = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            sh_d   = {rx_s_q, sh_q[DATA_BITS-1:1]};
            if (bidx_q == B_LAST) begin
              bidx_d  = '0;
              state_d = S_STOP;
            end else begin
              bidx_d = bidx_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            dout_d  = sh_q;
            valid_d = 1'b1;
            ferr_d  = ~rx_s_q;
            // Completion beats a same-cycle RD, so only an unread word counts as overrun.
            if (valid_q && !RD) begin
              ovr_d = 1'b1;
            end else begin
              ovr_d = ovr_q;
            end
            state_d = rx_s_q ? S_IDLE : S_WAITHI;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_WAITHI: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAITHI;
          end
        end
        default: begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          bidx_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      rx_m_q  <= rx_m_d;
      rx_s_q  <= rx_s_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign Dout     = dout_q;
  assign Valid    = valid_q;
  assign FrameErr = ferr_q;
  assign Overrun  = ovr_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: Clk period 10, divClk period 40 (tick every 4 Clk),
// nominal bit period 16 ticks = 640 time units.
module tb_uart_rx_sipo;

  localparam int BIT_T = 640;

  logic       Clk, Rst, divClk, Rx, RD;
  logic [8:0] Dout;
  logic       Valid, FrameErr, Overrun, Busy;
  int         n_chk;
  int         n_fail;

  uart_rx_sipo #(.OVERSAMPLE(16), .DATA_BITS(9)) dut (
    .Clk(Clk), .Rst(Rst), .divClk(divClk), .Rx(Rx), .RD(RD),
    .Dout(Dout), .Valid(Valid), .FrameErr(FrameErr), .Overrun(Overrun), .Busy(Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    divClk = 1'b0;
    forever #20 divClk = ~divClk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Start edge is placed 12 units before a divClk rise, so detection lands on the
  // posedge at start+27 and the stop-sample completion on the posedge at start+6747.
  task automatic send_frame(input logic [8:0] data, input logic stop, input int bt);
    @(posedge divClk);
    #28;
    Rx = 1'b0;
    #(bt);
    for (int i = 0; i < 9; i++) begin
      Rx = data[i];
      #(bt);
    end
    Rx = stop;
    #(bt);
  endtask

  task automatic rd_pulse();
    @(negedge Clk);
    RD = 1'b1;
    @(negedge Clk);
    RD = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge Clk);
    n_chk++; if (Dout !== 9'h000) begin n_fail++; $display("FAIL reset_dout got=%h exp=%h", Dout, 9'h000); end
    n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b0000); end
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b0000); end
  endtask

  task automatic test_single_frame();
    fork
      send_frame(9'h0A5, 1'b1, BIT_T);
      begin
        @(posedge divClk);
        #28;
        #200;
        n_chk++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid got=%b exp=%b", Busy, 1'b1); end
        #6542;
        n_chk++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early got=%b exp=%b", Valid, 1'b0); end
        #10;
        n_chk++; if (Valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_edge got=%b exp=%b", Valid, 1'b1); end
      end
    join
    #(2 * BIT_T);
    n_chk++; if (Dout !== 9'h0A5) begin n_fail++; $display("FAIL single_dout got=%h exp=%h", Dout, 9'h0A5); end
    n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b1000) begin n_fail++; $display("FAIL single_flags got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b1000); end
    rd_pulse();
    n_chk++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL single_rd_clear got=%b exp=%b", Valid, 1'b0); end
    n_chk++; if (Dout !== 9'h0A5) begin n_fail++; $display("FAIL single_rd_dout got=%h exp=%h", Dout, 9'h0A5); end
  endtask

  task automatic test_glitch();
    @(posedge divClk);
    #28;
    Rx = 1'b0;
    #160;
    Rx = 1'b1;
    #40;
    n_chk++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy got=%b exp=%b", Busy, 1'b1); end
    #(2 * BIT_T);
    n_chk++; if ({Valid, Busy} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags got=%b exp=%b", {Valid, Busy}, 2'b00); end
    n_chk++; if (Dout !== 9'h0A5) begin n_fail++; $display("FAIL glitch_dout got=%h exp=%h", Dout, 9'h0A5); end
  endtask

  task automatic test_framing_error();
    send_frame(9'h1FF, 1'b0, BIT_T);
    #(30 * 40);
    n_chk++; if (Dout !== 9'h1FF) begin n_fail++; $display("FAIL ferr_dout got=%h exp=%h", Dout, 9'h1FF); end
    n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b1101) begin n_fail++; $display("FAIL ferr_flags got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b1101); end
    rd_pulse();
    Rx = 1'b1;
    #(12 * BIT_T);
    n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b0100) begin n_fail++; $display("FAIL ferr_after_high got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b0100); end
    send_frame(9'h003, 1'b1, BIT_T);
    #(2 * BIT_T);
    n_chk++; if (Dout !== 9'h003) begin n_fail++; $display("FAIL ferr_next_dout got=%h exp=%h", Dout, 9'h003); end
    n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b1000) begin n_fail++; $display("FAIL ferr_next_flags got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b1000); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(9'h011, 1'b1, BIT_T);
    send_frame(9'h122, 1'b1, BIT_T);
    #(2 * BIT_T);
    n_chk++; if (Dout !== 9'h122) begin n_fail++; $display("FAIL ovr_dout got=%h exp=%h", Dout, 9'h122); end
    n_chk++; if ({Valid, FrameErr, Overrun} !== 3'b101) begin n_fail++; $display("FAIL ovr_flags got=%b exp=%b", {Valid, FrameErr, Overrun}, 3'b101); end
  endtask

  task automatic test_rd_collision();
    do_reset();
    n_chk++; if ({Valid, Overrun} !== 2'b00) begin n_fail++; $display("FAIL coll_reset got=%b exp=%b", {Valid, Overrun}, 2'b00); end
    send_frame(9'h011, 1'b1, BIT_T);
    fork
      send_frame(9'h122, 1'b1, BIT_T);
      begin
        @(posedge divClk);
        #28;
        #6742;
        RD = 1'b1;
        #10;
        RD = 1'b0;
        n_chk++; if (Valid !== 1'b1) begin n_fail++; $display("FAIL coll_valid_edge got=%b exp=%b", Valid, 1'b1); end
      end
    join
    #(2 * BIT_T);
    n_chk++; if (Dout !== 9'h122) begin n_fail++; $display("FAIL coll_dout got=%h exp=%h", Dout, 9'h122); end
    n_chk++; if ({Valid, FrameErr, Overrun} !== 3'b100) begin n_fail++; $display("FAIL coll_flags got=%b exp=%b", {Valid, FrameErr, Overrun}, 3'b100); end
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(9'h155, 1'b1, BIT_T);
      begin
        @(posedge divClk);
        #28;
        #(5 * BIT_T + 320);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        n_chk++; if (Dout !== 9'h000) begin n_fail++; $display("FAIL midrst_dout got=%h exp=%h", Dout, 9'h000); end
        n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b0000); end
      end
    join
    @(negedge Clk);
    Rst = 1'b0;
    #(2 * BIT_T);
    n_chk++; if ({Valid, Busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_quiet got=%b exp=%b", {Valid, Busy}, 2'b00); end
    send_frame(9'h0F0, 1'b1, BIT_T);
    #(2 * BIT_T);
    n_chk++; if (Dout !== 9'h0F0) begin n_fail++; $display("FAIL midrst_dout2 got=%h exp=%h", Dout, 9'h0F0); end
    n_chk++; if ({Valid, FrameErr, Overrun, Busy} !== 4'b1000) begin n_fail++; $display("FAIL midrst_flags2 got=%b exp=%b", {Valid, FrameErr, Overrun, Busy}, 4'b1000); end
    rd_pulse();
  endtask

  task automatic test_baud_skew();
    logic [8:0] words [3];
    int         bts [2];
    words = '{9'h000, 9'h1FF, 9'h0AA};
    bts   = '{660, 620};
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 3; w++) begin
        send_frame(words[w], 1'b1, bts[b]);
        #(2 * BIT_T);
        n_chk++; if (Dout !== words[w]) begin n_fail++; $display("FAIL skew_dout bt=%0d got=%h exp=%h", bts[b], Dout, words[w]); end
        n_chk++; if ({Valid, FrameErr} !== 2'b10) begin n_fail++; $display("FAIL skew_flags bt=%0d word=%h got=%b exp=%b", bts[b], words[w], {Valid, FrameErr}, 2'b10); end
        rd_pulse();
      end
    end
    n_chk++; if (Overrun !== 1'b0) begin n_fail++; $display("FAIL skew_overrun got=%b exp=%b", Overrun, 1'b0); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Rst    = 1'b1;
    Rx     = 1'b1;
    RD     = 1'b0;
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing_error();
    test_overrun();
    test_rd_collision();
    test_reset_midframe();
    test_baud_skew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

Serial-in/parallel-out UART receiver, the receive-side counterpart of the team's 11-bit-frame transmitter (start 0, 9 data bits LSB-first, stop 1; idle line high). It synchronizes the asynchronous RX line, finds the start edge using a 16x oversampling tick, and samples each bit at mid-bit. It then presents the 9-bit word with valid, framing-error and overrun flags to the host-side register logic. Bit 8 is delivered raw; parity checking is done downstream.

## Interface
- OVERSAMPLE, 16, sample ticks per bit; even, ≥4
- DATA_BITS, 9, data bits per frame
- Clk  in  1  system clock; all logic on posedge
- Rst  in  1  reset, synchronous, active-high
- divClk  in  1  free-running divided clock at OVERSAMPLE × baud. A rising edge is detected internally: tick = divClk & ~divClk_q, registered, so tick is a 1-Clk pulse one cycle after the edge.
- Rx  in  1  asynchronous serial line, idle high
- RD  in  1  host read strobe; clears Valid
- Dout  out  DATA_BITS  last received word
- Valid  out  1  word available, held until RD
- FrameErr  out  1  stop bit of the word in Dout sampled 0
- Overrun  out  1  sticky; a new word arrived while Valid=1 and RD=0. Cleared only by Rst.
- Busy  out  1  high in any state other than IDLE

## Operation
- Rx passes through 2 flops (rx_s) before use. Reset value of the synchronizer flops is 1.
- Bit-position and tick counters advance only on tick. No other logic is gated by tick except where stated.
- States:
  - IDLE: on tick with rx_s=0, go to START with tcnt=0.
  - START: on each tick, tcnt++. On the tick where tcnt reaches OVERSAMPLE/2−1:
    - rx_s=0: go to DATA with tcnt=0, bidx=0.
    - rx_s=1: false start; return to IDLE with no flags changed.
  - DATA: on each tick, tcnt++. When tcnt reaches OVERSAMPLE−1: sample, shift sh <= {rx_s, sh[DATA_BITS-1:1]}, tcnt=0, bidx++. After the bit with bidx=DATA_BITS−1, go to STOP.
  - STOP: on the tick where tcnt reaches OVERSAMPLE−1:
    - Dout <= sh; Valid <= 1; FrameErr <= ~rx_s.
    - If Valid was 1 and RD=0 in this cycle, Overrun <= 1.
    - Next state: rx_s=1 goes to IDLE; rx_s=0 goes to WAITHI.
  - WAITHI: stay until a tick with rx_s=1, then go to IDLE. This stops a break condition from being decoded as back-to-back frames.
- RD=1 clears Valid the next cycle. If RD and frame completion occur in the same cycle, the completion wins: Valid stays 1, Dout is updated, and no overrun is flagged.
- FrameErr is overwritten on every completed frame. It is not cleared by RD.
- Rst in any state: state=IDLE, counters=0, sh=0, Dout=0, Valid=0, FrameErr=0, Overrun=0, Busy=0. Any frame in progress is discarded.

## Timing
- Reset values: Dout=0, Valid=0, FrameErr=0, Overrun=0, Busy=0.
- Synchronizer plus edge detect give up to 3 Clk of input latency, plus up to 1 tick of start-detect quantization.
- Sampling points: the start bit at OVERSAMPLE/2 ticks after detection, then every OVERSAMPLE ticks. With the default of 16, data bit k is sampled at tick 8+16(k+1) and the stop bit at tick 8+16·10=168.
- Valid, Dout and FrameErr update together in the Clk cycle after the stop-sample tick.
- Busy rises the cycle after the start is detected. It falls the cycle after the transition back to IDLE.
- Transmitter and receiver clock mismatch tolerance is ≥ ±3% at OVERSAMPLE=16.
- Stop-bit sampling happens mid-stop. The next start edge may arrive from 0.5 bit after the stop-bit sample onward; back-to-back frames with a one-bit stop must decode without loss.

## Test plan
- Single frame: Rx carries data 9'h0A5 (start 0, bits LSB-first, stop 1), tick every 4 Clk. Required: Dout=9'h0A5, Valid=1, FrameErr=0, Overrun=0; Busy low after the stop bit.
- Glitch rejection: Rx low for 4 ticks, then high. Required: return to IDLE, Valid stays 0, Dout unchanged.
- Framing error: frame 9'h1FF with stop bit 0, Rx held low for a further 30 ticks. Required: Dout=9'h1FF, FrameErr=1, exactly one Valid. Only after Rx returns high is the next frame 9'h003 received with FrameErr=0.
- Overrun and RD collision:
  - Two frames 9'h011 and 9'h122 back-to-back with no RD. Required: Dout=9'h122, Overrun=1.
  - After Rst, repeat with RD asserted in the completion cycle of the second frame. Required: Valid=1, Overrun=0.
- Reset mid-frame: assert Rst during data bit 4 of 9'h155, then send 9'h0F0. Required: all outputs 0 immediately after Rst; only 9'h0F0 is reported.
- Baud skew: frames 9'h000, 9'h1FF and 9'h0AA sent with the transmitter bit period at +3% and −3% of nominal. Required: all words are correct with FrameErr=0.
